neopixel_rx: RTL

- One-wire WS2812 (NeoPixel) stream decoder: the receive end of the GRB protocol that our NeopixelController transmits.
- Samples the serial line at CLOCK_50 and classifies each high pulse width as a 0 or 1 bit.
- Assembles 24-bit GRB words and emits per-pixel colour with a valid pulse; detects the latch (reset) gap as end of frame.
- Used for loopback self-test of the LED chain and for receiving pixel data from the remote board.

---
 rtl/neopix_pkg.sv | 32 +++
 rtl/neopix_pulse_classifier.sv | 82 ++++++++
 rtl/synchronizer.sv | 31 +++
 rtl/neopixel_rx.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/neopix_pkg.sv
// -----------------------------------------------------------------------------
// neopix_pkg
// Shared definitions for the WS2812 (NeoPixel) receive path.
//   - Default pulse timing constants, in CLOCK_50 cycles (20 ns each).
//   - grb_t : one pixel in wire order (green first, then red, then blue).
//   - state_t : decoder FSM states.
// -----------------------------------------------------------------------------
package neopix_pkg;

  // A WS2812 '0' is nominally ~0.4 us high and a '1' ~0.8 us high. The
  // threshold sits between the two, with generous margins on either side.
  localparam int T_MIN_DEF    = 5;     // shorter high pulses are glitches
  localparam int T_THRESH_DEF = 30;    // high width >= this decodes as 1
  localparam int T_MAX_DEF    = 60;    // longest legal high width
  localparam int T_LATCH_DEF  = 2500;  // 50 us of low line ends a frame

  // Bits arrive MSB first as G[7:0], R[7:0], B[7:0], so a packed struct in
  // this field order maps directly onto the 24-bit shift register.
  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_t;

  typedef enum logic [1:0] {
    ST_WAIT_LATCH = 2'd0,  // unsynchronised: need a full latch gap first
    ST_IDLE       = 2'd1,  // synchronised, waiting for the first bit
    ST_HIGH       = 2'd2,  // measuring a high pulse
    ST_LOW        = 2'd3   // between bits, watching for the latch gap
  } state_t;

endpackage

// File: rtl/neopix_pulse_classifier.sv
// -----------------------------------------------------------------------------
// neopix_pulse_classifier
// Measures high and low run lengths on the synchronised NeoPixel line and
// turns them into single-cycle events. It knows nothing about framing; the
// decoder FSM decides which events matter in which state.
// Ports:
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   line      : synchronised serial line
//   rise      : line went high this sample
//   bit_valid : falling edge of a legal-width pulse
//   bit_value : decoded value, meaningful with bit_valid
//   glitch    : pulse too short (at its fall) or too long (at sample T_MAX+1)
//   latch     : this sample is the T_LATCH-th consecutive low sample
// -----------------------------------------------------------------------------
module neopix_pulse_classifier #(
  parameter int T_MIN    = 5,
  parameter int T_THRESH = 30,
  parameter int T_MAX    = 60,
  parameter int T_LATCH  = 2500
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic rise,
  output logic bit_valid,
  output logic bit_value,
  output logic glitch,
  output logic latch
);

  // High counter must hold T_MAX+1 (the saturation value that marks an
  // already-reported over-long pulse); low counter must hold T_LATCH.
  localparam int HW = $clog2(T_MAX + 2);
  localparam int LW = $clog2(T_LATCH + 1);

  localparam logic [HW-1:0] H_MIN   = HW'(T_MIN);
  localparam logic [HW-1:0] H_THR   = HW'(T_THRESH);
  localparam logic [HW-1:0] H_MAX   = HW'(T_MAX);
  localparam logic [LW-1:0] L_LATCH = LW'(T_LATCH);
  localparam logic [LW-1:0] L_LAST  = LW'(T_LATCH - 1);

  logic          line_q;
  logic          fall;
  logic [HW-1:0] hi_cnt;
  logic [LW-1:0] lo_cnt;

  assign rise = line & ~line_q;
  assign fall = ~line & line_q;

  // hi_cnt holds the number of high samples of the current/last pulse, so on
  // the falling-edge sample it is exactly the pulse width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= 1'b0;
      hi_cnt <= '0;
      lo_cnt <= '0;
    end else begin
      line_q <= line;
      if (line) begin
        lo_cnt <= '0;
        if (rise) begin
          hi_cnt <= {{(HW-1){1'b0}}, 1'b1};
        end else if (hi_cnt <= H_MAX) begin
          hi_cnt <= hi_cnt + 1'b1;
        end
      end else if (lo_cnt < L_LATCH) begin
        lo_cnt <= lo_cnt + 1'b1;
      end
    end
  end

  // A pulse that already saturated at T_MAX+1 was reported while still high,
  // so its eventual fall produces neither a bit nor a second glitch.
  assign bit_valid = fall && (hi_cnt >= H_MIN) && (hi_cnt <= H_MAX);
  assign bit_value = (hi_cnt >= H_THR);
  assign glitch    = (fall && (hi_cnt < H_MIN)) ||
                     (line && line_q && (hi_cnt == H_MAX));
  // lo_cnt saturates at T_LATCH, so this fires once per low run.
  assign latch     = ~line && (lo_cnt == L_LAST);

endmodule

// File: rtl/synchronizer.sv
// -----------------------------------------------------------------------------
// synchronizer
// Multi-flop synchroniser for a single asynchronous input bit.
// Ports:
//   clk : destination clock
//   rst : asynchronous active-high reset, clears every stage to 0
//   d   : asynchronous input
//   q   : synchronised output, STAGES cycles behind d
// -----------------------------------------------------------------------------
module synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/neopixel_rx.sv
// -----------------------------------------------------------------------------
// neopixel_rx
// WS2812 (NeoPixel) one-wire GRB stream decoder. Classifies each high pulse
// as a 0/1 bit, assembles 24-bit GRB pixels and detects the latch gap that
// ends a frame. Used for LED-chain loopback self-test and for receiving
// pixel data from the remote board.
// Ports:
//   CLOCK_50    : 50 MHz system clock
//   reset       : asynchronous active-high reset
//   neopixel_in : asynchronous serial data line
//   red/green/blue : colour of the last completed pixel (held)
//   pixel       : index of the pixel presented with pixel_valid
//   pixel_valid : one-cycle pulse when red/green/blue/pixel are new
//   frame_done  : one-cycle pulse on a clean latch
//   error       : one-cycle pulse on a timing or framing violation
//   busy        : high from the first accepted rising edge until the latch
// -----------------------------------------------------------------------------
module neopixel_rx
  import neopix_pkg::*;
#(
  parameter int NUM_PIXELS = 8,
  parameter int T_MIN      = T_MIN_DEF,
  parameter int T_THRESH   = T_THRESH_DEF,
  parameter int T_MAX      = T_MAX_DEF,
  parameter int T_LATCH    = T_LATCH_DEF
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic                          neopixel_in,
  output logic [7:0]                    red,
  output logic [7:0]                    green,
  output logic [7:0]                    blue,
  output logic [$clog2(NUM_PIXELS)-1:0] pixel,
  output logic                          pixel_valid,
  output logic                          frame_done,
  output logic                          error,
  output logic                          busy
);

  localparam int              IW       = $clog2(NUM_PIXELS);
  localparam logic [IW-1:0]   LAST_IDX = IW'(NUM_PIXELS - 1);

  logic line_s;
  logic rise;
  logic bit_valid;
  logic bit_value;
  logic glitch;
  logic latch;

  state_t        state;
  logic [22:0]   shift_q;   // first 23 bits of the pixel; the 24th completes it
  logic [4:0]    bit_cnt;
  logic [IW-1:0] idx;
  logic          idx_full;  // pixel NUM_PIXELS-1 already delivered this frame
  logic          px_seen;   // at least one full pixel (incl. overflow) this frame
  logic [23:0]   word_next;
  grb_t          word;

  // Two flops from the pin; the classifier's registered copy is the third,
  // giving a three-cycle pin-to-edge latency.
  synchronizer #(
    .STAGES (2)
  ) u_sync (
    .clk (CLOCK_50),
    .rst (reset),
    .d   (neopixel_in),
    .q   (line_s)
  );

  neopix_pulse_classifier #(
    .T_MIN    (T_MIN),
    .T_THRESH (T_THRESH),
    .T_MAX    (T_MAX),
    .T_LATCH  (T_LATCH)
  ) u_cls (
    .clk       (CLOCK_50),
    .rst       (reset),
    .line      (line_s),
    .rise      (rise),
    .bit_valid (bit_valid),
    .bit_value (bit_value),
    .glitch    (glitch),
    .latch     (latch)
  );

  assign word_next = {shift_q, bit_value};
  assign word      = word_next;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state       <= ST_WAIT_LATCH;
      shift_q     <= '0;
      bit_cnt     <= '0;
      idx         <= '0;
      idx_full    <= 1'b0;
      px_seen     <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      pixel       <= '0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      error       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      error       <= 1'b0;

      case (state)
        // The low counter in the classifier restarts on every high sample,
        // so a latch here really is T_LATCH uninterrupted low cycles.
        ST_WAIT_LATCH: begin
          if (latch) begin
            state <= ST_IDLE;
          end
        end

        ST_IDLE: begin
          if (rise) begin
            state <= ST_HIGH;
            busy  <= 1'b1;
          end
        end

        ST_HIGH: begin
          if (glitch) begin
            // Timing violation: abandon the frame and resynchronise.
            error    <= 1'b1;
            state    <= ST_WAIT_LATCH;
            busy     <= 1'b0;
            shift_q  <= '0;
            bit_cnt  <= '0;
            idx      <= '0;
            idx_full <= 1'b0;
            px_seen  <= 1'b0;
          end else if (bit_valid) begin
            state <= ST_LOW;
            if (bit_cnt == 5'd23) begin
              bit_cnt <= '0;
              shift_q <= '0;
              px_seen <= 1'b1;
              // Pixels past the end of the chain are still timed but not
              // presented; the index parks on the last pixel.
              if (!idx_full) begin
                green       <= word.g;
                red         <= word.r;
                blue        <= word.b;
                pixel       <= idx;
                pixel_valid <= 1'b1;
                if (idx == LAST_IDX) begin
                  idx_full <= 1'b1;
                end else begin
                  idx <= idx + 1'b1;
                end
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shift_q <= word_next[22:0];
            end
          end
        end

        ST_LOW: begin
          if (rise) begin
            state <= ST_HIGH;
          end else if (latch) begin
            // A latch mid-pixel is a framing error; otherwise the frame is
            // complete provided something was actually received.
            if (bit_cnt != 5'd0) begin
              error <= 1'b1;
            end else if (px_seen) begin
              frame_done <= 1'b1;
            end
            state    <= ST_IDLE;
            busy     <= 1'b0;
            shift_q  <= '0;
            bit_cnt  <= '0;
            idx      <= '0;
            idx_full <= 1'b0;
            px_seen  <= 1'b0;
          end
        end

        default: begin
          state <= ST_WAIT_LATCH;
        end
      endcase
    end
  end

endmodule
